mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, alongside RAM; consumes CPU stores to its address window.
- Buffers bytes in a TX FIFO and serialises them as 8N1 frames on a single output pin.
- Status reads let firmware poll for space and completion.
- Address decode of the window is external; `sel` is asserted only for accesses inside it.

---
 rtl/mmio_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO that a
// bit-timed FSM drains onto the tx pin; STATUS/BAUDDIV are readable for polling.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    input  logic [1:0]  mem_size,
    output logic [31:0] data_o,
    output logic        tx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] CNT_FULL = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_reg, state_next;
    logic [15:0]    timer_reg, timer_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [7:0]     shift_reg, shift_next;
    logic           tx_reg, tx_next;
    logic           irq_reg;
    logic [31:0]    data_o_reg;
    logic [15:0]    baud_div_reg;
    logic           overflow_reg;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]  count;
    logic [31:0]    count_ext;
    logic           full, empty, pop, push, push_req;
    logic           wr_acc, rd_acc;
    logic [1:0]     reg_sel;
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [7:0]     fifo_head;
    logic [31:0]    rd_data;
    logic           unused_bits;

    assign unused_bits = ^{mem_size, addr[1:0], data_i[31:16]};

    // A simultaneous write and read is treated as a write only.
    assign reg_sel  = addr[3:2];
    assign wr_acc   = sel & wr_en;
    assign rd_acc   = sel & rd_en & ~wr_en;
    assign push_req = wr_acc && (reg_sel == 2'd0);

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign count_ext = 32'(count);
    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign push      = push_req & (~full | pop);
    assign fifo_head = fifo_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Overflow set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_div_reg <= DIV_DEFAULT;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_acc && (reg_sel == 2'd2)) begin
                baud_div_reg <= data_i[15:0];
            end
            if (push_req && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_acc && (reg_sel == 2'd1) && data_i[3]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1: rd_data = {20'd0, count_ext[3:0], 4'd0, overflow_reg,
                             (state_reg != S_IDLE), empty, full};
            2'd2: rd_data = {16'd0, baud_div_reg};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_o_reg <= '0;
        end else if (rd_acc) begin
            data_o_reg <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            irq_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            irq_reg     <= empty & (state_reg == S_IDLE);
        end
    end

    // Timer reloads from the live divider at each bit boundary, so divider
    // writes only affect the next bit.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    timer_next = baud_div_reg;
                    state_next = S_START;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (timer_reg == 16'd0) begin
                    timer_next   = baud_div_reg;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                    tx_next      = shift_reg[0];
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_reg == 16'd0) begin
                    timer_next = baud_div_reg;
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            S_STOP: begin
                if (timer_reg == 16'd0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        timer_next = baud_div_reg;
                        state_next = S_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign data_o = data_o_reg;
    assign tx     = tx_reg;
    assign irq    = irq_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow, divider change mid-frame and reset mid-frame.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [31:0] data_i;
    logic [1:0]  mem_size;
    logic [31:0] data_o;
    logic        tx;
    logic        irq;

    int          n_total = 0;
    int          n_bad   = 0;
    int          mon_cpb = 1;
    bit          mon_en  = 1'b0;
    logic [7:0]  rx_q [$];

    mmio_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_DEFAULT(16'd433)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .data_i  (data_i),
        .mem_size(mem_size),
        .data_o  (data_o),
        .tx      (tx),
        .irq     (irq)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Bus tasks start and end on a falling edge; the access lands on the
    // rising edge in between, so back-to-back calls are consecutive cycles.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; wr_en = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        sel = 1'b0; wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; rd_en = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; rd_en = 1'b0;
        d = data_o;
    endtask

    // Serial monitor: samples each bit at its middle using the known divider.
    initial begin : uart_mon
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx === 1'b0) begin
                repeat (mon_cpb / 2) @(negedge clk);
                check("mon_start", 32'(tx), 32'h0);
                for (int k = 0; k < 8; k++) begin
                    repeat (mon_cpb) @(negedge clk);
                    b[k] = tx;
                end
                repeat (mon_cpb) @(negedge clk);
                check("mon_stop", 32'(tx), 32'h1);
                rx_q.push_back(b);
                $display("mon  rx byte %02h", b);
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [9:0]  frame;
        logic [19:0] exp20;
        int          n;
        int          low_cnt;
        int          hi_cnt;
        int          tx_bad;

        reset = 1'b0; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; data_i = '0; mem_size = 2'b10;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_irq", 32'(irq), 32'h1);
        check("rst_data_o", data_o, 32'h0);
        reset = 1'b1;
        bus_read(4'h4, rd);  check("rst_status", rd, 32'h0000_0002);
        bus_read(4'h8, rd);  check("rst_bauddiv", rd, 32'd433);
        bus_read(4'h0, rd);  check("rd_txdata_zero", rd, 32'h0);
        bus_read(4'hC, rd);  check("rd_0xc_zero", rd, 32'h0);
        bus_read(4'hB, rd);  check("rd_low_addr_ignored", rd, 32'd433);

        // Write and read together: write lands, data_o holds
        sel = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 4'h8; data_i = 32'hFFFF_0005;
        @(negedge clk);
        sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("wr_wins_hold", data_o, 32'd433);
        bus_read(4'h8, rd);  check("wr_wins_value", rd, 32'd5);

        // Single byte 0xA5 at 4 clocks per bit
        bus_write(4'h8, 32'd3);
        mon_cpb = 4; rx_q.delete(); mon_en = 1'b1;
        bus_write(4'h0, 32'hA5);
        check("single_irq_pre", 32'(irq), 32'h1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("single_tx_c%0d", i), 32'(tx), 32'(frame[i / 4]));
        end
        @(negedge clk);
        bus_read(4'h4, rd);  check("single_status_done", rd, 32'h0000_0002);
        check("single_irq_post", 32'(irq), 32'h1);
        check("single_rx_n", rx_q.size(), 32'd1);
        check("single_rx_b", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hA5);
        mon_en = 1'b0;

        // Back-to-back frames at 1 clock per bit
        bus_write(4'h8, 32'd0);
        mon_cpb = 1; rx_q.delete(); mon_en = 1'b1;
        bus_write(4'h0, 32'h55);
        bus_write(4'h0, 32'h0F);
        exp20 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 20; i++) begin
            check($sformatf("b2b_tx_c%0d", i), 32'(tx), 32'(exp20[i]));
            if (i == 0) begin
                sel = 1'b1; rd_en = 1'b1; addr = 4'h4;
            end
            if (i == 1) begin
                sel = 1'b0; rd_en = 1'b0;
                check("b2b_status", data_o, 32'h0000_0104);
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("b2b_irq", 32'(irq), 32'h1);
        check("b2b_rx_n", rx_q.size(), 32'd2);
        check("b2b_rx_0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h55);
        check("b2b_rx_1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD, 32'h0F);
        mon_en = 1'b0;

        // Overflow: 9 bytes fit (one in flight), the 10th is dropped
        bus_write(4'h8, 32'd100);
        mon_cpb = 101; rx_q.delete(); mon_en = 1'b1;
        for (int b = 0; b < 9; b++) bus_write(4'h0, 32'(b));
        bus_read(4'h4, rd);  check("ovf_full_no_ovf", rd, 32'h0000_0805);
        bus_write(4'h0, 32'h09);
        bus_read(4'h4, rd);  check("ovf_set", rd, 32'h0000_080D);
        bus_write(4'h4, 32'h0000_0008);
        bus_read(4'h4, rd);  check("ovf_cleared", rd, 32'h0000_0805);
        n = 0;
        while (irq !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check("ovf_drain_done", 32'(irq), 32'h1);
        @(negedge clk);
        check("ovf_rx_n", rx_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("ovf_rx_%0d", i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(i));
        end
        mon_en = 1'b0;

        // Divider change during the start bit
        bus_write(4'h8, 32'd7);
        bus_write(4'h0, 32'hFF);
        bus_write(4'h8, 32'd1);
        check("div_start_low", 32'(tx), 32'h0);
        low_cnt = 0;
        while (tx === 1'b0 && low_cnt < 50) begin
            low_cnt++;
            @(negedge clk);
        end
        check("div_start_len", low_cnt, 32'd8);
        hi_cnt = 0;
        tx_bad = 0;
        while (irq !== 1'b1 && hi_cnt < 100) begin
            if (tx !== 1'b1) tx_bad++;
            @(negedge clk);
            hi_cnt++;
        end
        check("div_data_stop_len", hi_cnt, 32'd19);
        check("div_tx_high", tx_bad, 32'd0);
        bus_read(4'h8, rd);  check("div_new_value", rd, 32'd1);

        // Reset during data bits of 0x3C with two bytes queued
        bus_write(4'h8, 32'd3);
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'h11);
        bus_write(4'h0, 32'h22);
        repeat (4) @(negedge clk);
        check("rstm_pre_tx", 32'(tx), 32'h0);
        reset = 1'b0;
        #1;
        check("rstm_tx", 32'(tx), 32'h1);
        check("rstm_irq", 32'(irq), 32'h1);
        check("rstm_data_o", data_o, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(4'h4, rd);  check("rstm_status", rd, 32'h0000_0002);
        tx_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
        end
        check("rstm_quiet", tx_bad, 32'd0);
        check("rstm_irq_post", 32'(irq), 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
